// File: rtl/mem_wb_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_skid_stage_if
// Description : Handshake, payload, forwarding and status bundle of the
//               MEM/WB skid stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_skid_stage_if #(
    parameter int INST_W = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [DATA_W-1:0] in_res;
    logic              in_wr_en;
    logic [ADDR_W-1:0] in_wr_addr;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [DATA_W-1:0] out_res;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  stall_cnt;

    // Environment side: memory stage upstream, writeback downstream
    modport master (
        output flush, in_valid, in_inst, in_res, in_wr_en, in_wr_addr, out_ready,
        input  in_ready, out_valid, out_inst, out_res, out_wr_en, out_wr_addr,
               fwd_valid, fwd_addr, fwd_data, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_inst, in_res, in_wr_en, in_wr_addr, out_ready,
        output in_ready, out_valid, out_inst, out_res, out_wr_en, out_wr_addr,
               fwd_valid, fwd_addr, fwd_data, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_skid_stage
// Description : MEM/WB pipeline register with 2-entry skid buffer, flush,
//               zero-register write suppression, forwarding tap and stall count.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_skid_stage #(
    parameter int INST_W      = 16,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int ZERO_REG_RO = 1,
    parameter int CNT_W       = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_wb_skid_stage_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              r_m_valid;
    logic [INST_W-1:0] r_m_inst;
    logic [DATA_W-1:0] r_m_res;
    logic              r_m_wr_en;
    logic [ADDR_W-1:0] r_m_wr_addr;

    logic              r_s_valid;
    logic [INST_W-1:0] r_s_inst;
    logic [DATA_W-1:0] r_s_res;
    logic              r_s_wr_en;
    logic [ADDR_W-1:0] r_s_wr_addr;

    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_in_ready;
    logic w_accept;
    logic w_m_load;
    logic w_zero_block;
    logic w_wr_en;

    // Ready depends only on skid occupancy, so it never combinationally follows out_ready
    assign w_in_ready   = !r_s_valid;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_m_load     = !r_m_valid || bus.out_ready;
    assign w_zero_block = (ZERO_REG_RO != 0) && (r_m_wr_addr == '0);
    assign w_wr_en      = r_m_valid && r_m_wr_en && !w_zero_block;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_m_valid   <= 1'b0;
            r_m_inst    <= '0;
            r_m_res     <= '0;
            r_m_wr_en   <= 1'b0;
            r_m_wr_addr <= '0;
            r_s_valid   <= 1'b0;
            r_s_inst    <= '0;
            r_s_res     <= '0;
            r_s_wr_en   <= 1'b0;
            r_s_wr_addr <= '0;
        end else if (w_m_load) begin
            if (r_s_valid) begin
                r_m_valid   <= 1'b1;
                r_m_inst    <= r_s_inst;
                r_m_res     <= r_s_res;
                r_m_wr_en   <= r_s_wr_en;
                r_m_wr_addr <= r_s_wr_addr;
                r_s_valid   <= 1'b0;
                r_s_inst    <= '0;
                r_s_res     <= '0;
                r_s_wr_en   <= 1'b0;
                r_s_wr_addr <= '0;
            end else if (w_accept) begin
                r_m_valid   <= 1'b1;
                r_m_inst    <= bus.in_inst;
                r_m_res     <= bus.in_res;
                r_m_wr_en   <= bus.in_wr_en;
                r_m_wr_addr <= bus.in_wr_addr;
            end else begin
                r_m_valid   <= 1'b0;
                r_m_inst    <= '0;
                r_m_res     <= '0;
                r_m_wr_en   <= 1'b0;
                r_m_wr_addr <= '0;
            end
        end else if (w_accept) begin
            r_s_valid   <= 1'b1;
            r_s_inst    <= bus.in_inst;
            r_s_res     <= bus.in_res;
            r_s_wr_en   <= bus.in_wr_en;
            r_s_wr_addr <= bus.in_wr_addr;
        end
    end

    // Survives flush so software can still read how long writeback stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_m_valid && !bus.out_ready && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_m_valid;
    assign bus.out_inst    = r_m_valid ? r_m_inst    : '0;
    assign bus.out_res     = r_m_valid ? r_m_res     : '0;
    assign bus.out_wr_addr = r_m_valid ? r_m_wr_addr : '0;
    assign bus.out_wr_en   = w_wr_en;
    assign bus.fwd_valid   = w_wr_en;
    assign bus.fwd_addr    = r_m_valid ? r_m_wr_addr : '0;
    assign bus.fwd_data    = r_m_valid ? r_m_res     : '0;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_skid_stage
// Description : Scoreboard bench for mem_wb_skid_stage (default, ZERO_REG_RO=0
//               and CNT_W=3 instances share one stimulus stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_skid_stage;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] res;
        logic [2:0]  addr;
        logic        wen;
        int          cyc;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_inst;
    logic [15:0] in_res;
    logic        in_wr_en;
    logic [2:0]  in_wr_addr;

    entry_t sb[$];
    int     checks;
    int     errors;
    int     cyc;
    bit     strict_lat;

    mem_wb_skid_stage_if #(.INST_W(16), .DATA_W(16), .ADDR_W(3), .CNT_W(8)) bus ();
    mem_wb_skid_stage_if #(.INST_W(16), .DATA_W(16), .ADDR_W(3), .CNT_W(8)) bus_z0 ();
    mem_wb_skid_stage_if #(.INST_W(16), .DATA_W(16), .ADDR_W(3), .CNT_W(3)) bus_c3 ();

    assign bus.flush      = flush;
    assign bus.in_valid   = in_valid;
    assign bus.in_inst    = in_inst;
    assign bus.in_res     = in_res;
    assign bus.in_wr_en   = in_wr_en;
    assign bus.in_wr_addr = in_wr_addr;
    assign bus.out_ready  = out_ready;

    assign bus_z0.flush      = flush;
    assign bus_z0.in_valid   = in_valid;
    assign bus_z0.in_inst    = in_inst;
    assign bus_z0.in_res     = in_res;
    assign bus_z0.in_wr_en   = in_wr_en;
    assign bus_z0.in_wr_addr = in_wr_addr;
    assign bus_z0.out_ready  = out_ready;

    assign bus_c3.flush      = flush;
    assign bus_c3.in_valid   = in_valid;
    assign bus_c3.in_inst    = in_inst;
    assign bus_c3.in_res     = in_res;
    assign bus_c3.in_wr_en   = in_wr_en;
    assign bus_c3.in_wr_addr = in_wr_addr;
    assign bus_c3.out_ready  = out_ready;

    mem_wb_skid_stage #(.INST_W(16), .DATA_W(16), .ADDR_W(3), .ZERO_REG_RO(1), .CNT_W(8))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));
    mem_wb_skid_stage #(.INST_W(16), .DATA_W(16), .ADDR_W(3), .ZERO_REG_RO(0), .CNT_W(8))
        dut_z0 (.clk(clk), .rst(rst), .bus(bus_z0.slave));
    mem_wb_skid_stage #(.INST_W(16), .DATA_W(16), .ADDR_W(3), .ZERO_REG_RO(1), .CNT_W(3))
        dut_c3 (.clk(clk), .rst(rst), .bus(bus_c3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One clock: compare/pop drained output and push accepted input at negedge
    task automatic cycle();
        entry_t e;
        @(negedge clk);
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got res=%h addr=%0d, expected no entry",
                             bus.out_res, bus.out_wr_addr);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_res !== e.res || bus.out_inst !== e.inst ||
                        bus.out_wr_addr !== e.addr || bus.out_wr_en !== e.wen ||
                        bus.fwd_valid !== e.wen || bus.fwd_data !== e.res ||
                        bus.fwd_addr !== e.addr) begin
                        errors++;
                        $display("FAIL out_entry: got inst=%h res=%h addr=%0d wen=%b fwd=%b/%0d/%h, expected inst=%h res=%h addr=%0d wen=%b",
                                 bus.out_inst, bus.out_res, bus.out_wr_addr, bus.out_wr_en,
                                 bus.fwd_valid, bus.fwd_addr, bus.fwd_data,
                                 e.inst, e.res, e.addr, e.wen);
                    end
                    if (strict_lat) begin
                        checks++;
                        if (cyc !== e.cyc + 1) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, expected 1", cyc - e.cyc);
                        end
                    end
                end
            end
            if (in_valid && bus.in_ready) begin
                e.inst = in_inst;
                e.res  = in_res;
                e.addr = in_wr_addr;
                e.wen  = in_wr_en && (in_wr_addr != 3'd0);
                e.cyc  = cyc;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [2:0] addr,
                         input logic wen);
        in_valid   = v;
        in_res     = res;
        in_wr_addr = addr;
        in_wr_en   = wen;
        in_inst    = res ^ 16'hC300;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_wr_en !== 1'b0 ||
            bus.fwd_valid !== 1'b0 || bus.out_res !== 16'h0 || bus.out_inst !== 16'h0 ||
            bus.out_wr_addr !== 3'd0) begin
            errors++;
            $display("FAIL %s: got valid=%b ready=%b wen=%b fwd=%b res=%h inst=%h addr=%0d, expected 0 1 0 0 0 0 0",
                     name, bus.out_valid, bus.in_ready, bus.out_wr_en, bus.fwd_valid,
                     bus.out_res, bus.out_inst, bus.out_wr_addr);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_idle("reset_outputs");
        checks++;
        if (bus.stall_cnt !== 8'd0 || bus_c3.stall_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d/%0d, expected 0/0",
                     bus.stall_cnt, bus_c3.stall_cnt);
        end
    endtask

    task automatic test_streaming();
        out_ready  = 1'b1;
        strict_lat = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 16'(i), 3'(i), 1'b1);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: got %b, expected 1", bus.in_ready);
            end
            cycle();
        end
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        cycle();
        cycle();
        strict_lat = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        drive(1'b1, 16'h000A, 3'd2, 1'b1);
        cycle();
        drive(1'b1, 16'h000B, 3'd3, 1'b1);
        cycle();
        drive(1'b1, 16'h000C, 3'd4, 1'b1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_res !== 16'h000A ||
                bus.out_wr_addr !== 3'd2) begin
                errors++;
                $display("FAIL bp_hold: got ready=%b valid=%b res=%h addr=%0d, expected 0 1 000a 2",
                         bus.in_ready, bus.out_valid, bus.out_res, bus.out_wr_addr);
            end
            cycle();
        end
        checks++;
        if (bus.stall_cnt !== 8'd3) begin
            errors++;
            $display("FAIL bp_stall_cnt: got %0d, expected 3", bus.stall_cnt);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        cycle();
        cycle();
        checks++;
        if (bus.stall_cnt !== 8'd3 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_final: got stall_cnt=%0d pending=%0d, expected 3 0",
                     bus.stall_cnt, sb.size());
        end
    endtask

    task automatic test_zero_reg();
        out_ready = 1'b1;
        drive(1'b1, 16'h0055, 3'd0, 1'b1);
        cycle();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_wr_en !== 1'b0 || bus.fwd_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg_ro1: got valid=%b wen=%b fwd=%b, expected 1 0 0",
                     bus.out_valid, bus.out_wr_en, bus.fwd_valid);
        end
        checks++;
        if (bus_z0.out_valid !== 1'b1 || bus_z0.out_wr_en !== 1'b1 ||
            bus_z0.fwd_valid !== 1'b1 || bus_z0.fwd_data !== 16'h0055) begin
            errors++;
            $display("FAIL zero_reg_ro0: got valid=%b wen=%b fwd=%b data=%h, expected 1 1 1 0055",
                     bus_z0.out_valid, bus_z0.out_wr_en, bus_z0.fwd_valid, bus_z0.fwd_data);
        end
        cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 16'h00D1, 3'd5, 1'b1);
        cycle();
        drive(1'b1, 16'h00D2, 3'd6, 1'b1);
        cycle();
        drive(1'b1, 16'h00D3, 3'd7, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        check_idle("flush_idle");
        out_ready = 1'b1;
        repeat (3) cycle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: got valid=%b res=%h, expected 0", bus.out_valid, bus.out_res);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        out_ready = 1'b0;
        drive(1'b1, 16'h0077, 3'd1, 1'b1);
        cycle();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        repeat (10) cycle();
        checks++;
        if (bus_c3.stall_cnt !== 3'd7 || bus.stall_cnt !== 8'd10) begin
            errors++;
            $display("FAIL sat_count: got c3=%0d c8=%0d, expected 7 10",
                     bus_c3.stall_cnt, bus.stall_cnt);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (bus_c3.stall_cnt !== 3'd7) begin
            errors++;
            $display("FAIL sat_after_flush: got %0d, expected 7", bus_c3.stall_cnt);
        end
        apply_reset();
        checks++;
        if (bus_c3.stall_cnt !== 3'd0) begin
            errors++;
            $display("FAIL sat_after_rst: got %0d, expected 0", bus_c3.stall_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, 16'h00E1, 3'd1, 1'b1);
        cycle();
        drive(1'b1, 16'h00E2, 3'd2, 1'b1);
        cycle();
        drive(1'b1, 16'h00E9, 3'd3, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        check_idle("midrst_idle");
        checks++;
        if (bus.stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midrst_stall_cnt: got %0d, expected 0", bus.stall_cnt);
        end
        out_ready  = 1'b1;
        strict_lat = 1'b1;
        drive(1'b1, 16'h00E3, 3'd4, 1'b1);
        cycle();
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        cycle();
        cycle();
        strict_lat = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drive(1'b0, 16'h0, 3'd0, 1'b0);
        out_ready = 1'b1;
        repeat (4) cycle();
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got pending=%0d valid=%b, expected 0 0",
                     sb.size(), bus.out_valid);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        strict_lat = 1'b0;
        rst        = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 1'b0);

        test_reset();
        test_streaming();
        test_backpressure();
        test_zero_reg();
        test_flush();
        test_saturation();
        test_reset_midstream();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake, a 2-entry skid buffer, flush, and a writeback-forwarding tap.
- Sits between the memory stage and the register-file write port.
- Carries instruction, result, write-enable and write address.
- Adds backpressure tolerance, bubble gating, zero-register write suppression and a saturating stall counter.

Parameters:
- INST_W, 16, instruction word width
- DATA_W, 16, result width
- ADDR_W, 3, register-file address width
- ZERO_REG_RO, 1, when 1 writes to address 0 are suppressed at the output (wr_en forced 0)
- CNT_W, 8, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_inst  in  INST_W  instruction
- in_res  in  DATA_W  result
- in_wr_en  in  1  register write request
- in_wr_addr  in  ADDR_W  destination register
- out_valid  out  1  output entry valid
- out_ready  in  1  writeback accepts the entry
- out_inst  out  INST_W  instruction
- out_res  out  DATA_W  result
- out_wr_en  out  1  gated register write enable
- out_wr_addr  out  ADDR_W  destination register
- fwd_valid  out  1  forwarding tap active
- fwd_addr  out  ADDR_W  forwarding register
- fwd_data  out  DATA_W  forwarding value
- stall_cnt  out  CNT_W  cycles held under backpressure

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset clears every output and internal register to 0: main and skid valids, payloads and stall_cnt.
- in_ready is registered: in_ready = !skid_valid. It is 1 in the cycle after reset.
- Accept: in_valid & in_ready at a clock edge. Drain: out_valid & out_ready at a clock edge.
- Latency: an accepted entry appears on the out_* ports the next cycle when the main register is empty or draining.
- Storage: main register (M) drives the outputs. Skid register (S) is used only when M is held.
  - Accept, M empty or draining, S empty: entry goes to M.
  - Accept while M is held (out_ready=0): entry goes to S, and in_ready drops the next cycle.
  - Drain with S full: S moves to M, S is cleared, and in_ready rises the next cycle.
  - Simultaneous accept and drain with S empty: the new entry replaces M. There is no bubble; full throughput is 1 entry/cycle.
- Ordering is strictly FIFO. Entries are never duplicated or lost except by flush.
- Held output: while out_valid & !out_ready, all out_* values stay stable.
- Bubble gating: out_wr_en = M_valid & M_wr_en & !(ZERO_REG_RO && M_wr_addr==0).
  - out_inst, out_res and out_wr_addr are 0 while out_valid=0.
- Forwarding tap: fwd_valid = out_wr_en. fwd_addr = out_wr_addr and fwd_data = out_res, both combinational from M.
- Flush: at the edge it clears the M and S valids and their payloads.
  - An in_valid in the same cycle is dropped.
  - Flush takes priority over accept, drain and reset-free transfers. Reset takes priority over flush.
  - The cycle after a flush: out_valid=0, in_ready=1.
- stall_cnt increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by rst; flush does not clear it.
- Reset mid-operation: all held entries are discarded and no write enable is asserted in the following cycle.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 5 cycles, in_res=1..5, in_wr_addr=1..5, in_wr_en=1 -> out_res=1..5 on consecutive cycles starting one cycle after the first accept; fwd_valid=1 and fwd_data matches out_res each cycle; in_ready stays 1.
- Backpressure: send res=0xA, 0xB, 0xC back to back with out_ready=0 -> 0xA held in M, 0xB in S, in_ready=0, 0xC not accepted; raise out_ready -> outputs 0xA, 0xB, then 0xC after re-offer; stall_cnt equals the number of held cycles.
- Zero register: in_wr_en=1, in_wr_addr=0, ZERO_REG_RO=1 -> out_valid=1, out_wr_en=0, fwd_valid=0; with ZERO_REG_RO=0 -> out_wr_en=1.
- Flush with S full plus a new in_valid in the same cycle -> next cycle out_valid=0, in_ready=1, out_wr_en=0; the new entry never appears.
- Saturation: CNT_W=3, hold out_valid with out_ready=0 for 10 cycles -> stall_cnt reaches 7 and stays 7; flush leaves it at 7; rst sets it to 0.
- Reset mid-stream: assert rst while M and S are valid -> next cycle all outputs 0, in_ready=1; the first entry after reset passes through with 1-cycle latency.
